// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch port and data load/store port share one physical port.
// Define MEM_ARBITER_RR_EN to alternate grants when both ports request; the default gives the data port fixed priority.
`timescale 1ns/1ps
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  // instruction side
  input  logic        mem_read1,
  input  logic [15:0] mem_addr1,
  output logic [15:0] mem_rdata1,
  output logic        mem_resp1,
  // data side
  input  logic        mem_read2,
  input  logic        mem_write2,
  input  logic [15:0] mem_addr2,
  input  logic [15:0] mem_wdata2,
  input  logic [1:0]  mem_byte_enable2,
  output logic [15:0] mem_rdata2,
  output logic        mem_resp2,
  // physical side
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_enable,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServeI = 2'd1,
    StServeD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        req_d;
  logic        grant_d;
  logic        grant_i;

`ifdef MEM_ARBITER_RR_EN
  // 1 = instruction port won the last grant, 0 = data port
  logic        last_i_q, last_i_d;
`endif

  assign req_d = mem_read2 | mem_write2;

  always_comb begin
    grant_d = req_d;
    grant_i = mem_read1 & ~req_d;
`ifdef MEM_ARBITER_RR_EN
    if (req_d && mem_read1) begin
      grant_d = last_i_q;
      grant_i = ~last_i_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
`ifdef MEM_ARBITER_RR_EN
    last_i_d = last_i_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d = StServeD;
          addr_d  = mem_addr2;
          wdata_d = mem_wdata2;
          be_d    = mem_byte_enable2;
          // read and write together resolve to a write
          wr_d    = mem_write2;
          rd_d    = ~mem_write2;
`ifdef MEM_ARBITER_RR_EN
          last_i_d = 1'b0;
`endif
        end else if (grant_i) begin
          state_d = StServeI;
          addr_d  = mem_addr1;
          wdata_d = '0;
          be_d    = '0;
          wr_d    = 1'b0;
          rd_d    = 1'b1;
`ifdef MEM_ARBITER_RR_EN
          last_i_d = 1'b1;
`endif
        end
      end
      StServeI, StServeD: begin
        if (pmem_resp) begin
          state_d = StIdle;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_i_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
`ifdef MEM_ARBITER_RR_EN
      last_i_q <= last_i_d;
`endif
    end
  end

  assign pmem_read        = rd_q;
  assign pmem_write       = wr_q;
  assign pmem_address     = addr_q;
  assign pmem_wdata       = wdata_q;
  assign pmem_byte_enable = be_q;

  assign mem_resp1  = pmem_resp & (state_q == StServeI);
  assign mem_resp2  = pmem_resp & (state_q == StServeD);
  assign mem_rdata1 = pmem_rdata;
  assign mem_rdata2 = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (default build: fixed data-port priority).
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read1;
  logic [15:0] mem_addr1;
  logic [15:0] mem_rdata1;
  logic        mem_resp1;
  logic        mem_read2;
  logic        mem_write2;
  logic [15:0] mem_addr2;
  logic [15:0] mem_wdata2;
  logic [1:0]  mem_byte_enable2;
  logic [15:0] mem_rdata2;
  logic        mem_resp2;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read1        (mem_read1),
    .mem_addr1        (mem_addr1),
    .mem_rdata1       (mem_rdata1),
    .mem_resp1        (mem_resp1),
    .mem_read2        (mem_read2),
    .mem_write2       (mem_write2),
    .mem_addr2        (mem_addr2),
    .mem_wdata2       (mem_wdata2),
    .mem_byte_enable2 (mem_byte_enable2),
    .mem_rdata2       (mem_rdata2),
    .mem_resp2        (mem_resp2),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
  );

  typedef struct packed {
    logic        d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdata;
  } txn_t;

  txn_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic d, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [1:0] be, input logic [15:0] rdata);
    txn_t t;
    t.d = d; t.wr = wr; t.addr = addr; t.wdata = wdata; t.be = be; t.rdata = rdata;
    sb_q.push_back(t);
  endtask

  task automatic check_bus(input txn_t t);
    check("pmem_address", pmem_address, t.addr);
    check("pmem_read", pmem_read, !t.wr);
    check("pmem_write", pmem_write, t.wr);
    if (t.wr) begin
      check("pmem_wdata", pmem_wdata, t.wdata);
      check("pmem_be", pmem_byte_enable, t.be);
    end
  endtask

  // Plays the memory for the oldest expected transaction; drop masks which requests
  // to release (and scramble) once service has started: bit0 fetch, bit1 data.
  task automatic respond(input int lat, input logic [1:0] drop);
    txn_t t;
    int   n;
    if (sb_q.size() == 0) begin
      check("sb_empty", 0, 1);
      return;
    end
    t = sb_q.pop_front();
    n = 0;
    @(negedge clk);
    while (!(pmem_read || pmem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("strobe_timeout", 0, 1);
      return;
    end
    if (drop[0]) begin
      mem_read1 = 1'b0;
      mem_addr1 = mem_addr1 + 16'h1000;
    end
    if (drop[1]) begin
      mem_read2        = 1'b0;
      mem_write2       = 1'b0;
      mem_addr2        = mem_addr2 + 16'h1000;
      mem_wdata2       = ~mem_wdata2;
      mem_byte_enable2 = ~mem_byte_enable2;
    end
    for (int i = 0; i < lat; i++) begin
      #1;
      check_bus(t);
      check("resp1_early", mem_resp1, 0);
      check("resp2_early", mem_resp2, 0);
      @(negedge clk);
    end
    pmem_rdata = t.rdata;
    pmem_resp  = 1'b1;
    #1;
    check_bus(t);
    check("resp1", mem_resp1, !t.d);
    check("resp2", mem_resp2, t.d);
    if (!t.wr) check(t.d ? "rdata2" : "rdata1", t.d ? mem_rdata2 : mem_rdata1, t.rdata);
    @(posedge clk);
    #1;
    pmem_resp  = 1'b0;
    pmem_rdata = 16'hdead;
    @(negedge clk);
    check("turnaround", {pmem_read, pmem_write}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    mem_read1 = 0; mem_addr1 = 0;
    mem_read2 = 0; mem_write2 = 0; mem_addr2 = 0; mem_wdata2 = 0; mem_byte_enable2 = 0;
    pmem_rdata = 16'hdead; pmem_resp = 0;
    #1;
    check("rst_read", pmem_read, 0);
    check("rst_write", pmem_write, 0);
    check("rst_addr", pmem_address, 0);
    check("rst_wdata", pmem_wdata, 0);
    check("rst_be", pmem_byte_enable, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Fetch only, released mid-service
    push(1'b0, 1'b0, 16'h3000, 16'h0, 2'b00, 16'h1234);
    mem_read1 = 1; mem_addr1 = 16'h3000;
    respond(3, 2'b01);

    // Simultaneous: data first (addr changes mid-service), then fetch
    @(posedge clk); #1;
    push(1'b1, 1'b1, 16'h4000, 16'hbeef, 2'b01, 16'h0);
    push(1'b0, 1'b0, 16'h3000, 16'h0, 2'b00, 16'h5a5a);
    mem_read1 = 1; mem_addr1 = 16'h3000;
    mem_write2 = 1; mem_addr2 = 16'h4000; mem_wdata2 = 16'hbeef; mem_byte_enable2 = 2'b01;
    respond(3, 2'b10);
    respond(2, 2'b01);

    // Read and write together resolve to a write
    @(posedge clk); #1;
    push(1'b1, 1'b1, 16'h6000, 16'h1111, 2'b11, 16'h0);
    mem_read2 = 1; mem_write2 = 1; mem_addr2 = 16'h6000; mem_wdata2 = 16'h1111;
    mem_byte_enable2 = 2'b11;
    respond(2, 2'b10);

    // Data load
    @(posedge clk); #1;
    push(1'b1, 1'b0, 16'h7000, 16'h0, 2'b10, 16'hcafe);
    mem_read2 = 1; mem_addr2 = 16'h7000; mem_byte_enable2 = 2'b10;
    respond(1, 2'b10);

    // Fetch held past its resp is served again
    @(posedge clk); #1;
    push(1'b0, 1'b0, 16'h2222, 16'h0, 2'b00, 16'h0101);
    push(1'b0, 1'b0, 16'h2222, 16'h0, 2'b00, 16'h0202);
    mem_read1 = 1; mem_addr1 = 16'h2222;
    respond(2, 2'b00);
    respond(1, 2'b01);

    // Stray resp in IDLE
    @(negedge clk);
    pmem_resp = 1; pmem_rdata = 16'h9999;
    #1;
    check("stray_resp1", mem_resp1, 0);
    check("stray_resp2", mem_resp2, 0);
    @(negedge clk);
    check("stray_idle", {pmem_read, pmem_write}, 0);
    pmem_resp = 0;

    // Reset mid-fetch
    @(posedge clk); #1;
    mem_read1 = 1; mem_addr1 = 16'h3000;
    n = 0;
    @(negedge clk);
    while (!pmem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_strobe", pmem_read, 1);
    reset = 1; pmem_resp = 1;
    #1;
    check("rstmid_read", pmem_read, 0);
    check("rstmid_addr", pmem_address, 0);
    check("rstmid_resp1", mem_resp1, 0);
    mem_read1 = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("post_rst_resp1", mem_resp1, 0);
    check("post_rst_resp2", mem_resp2, 0);
    check("post_rst_idle", {pmem_read, pmem_write}, 0);
    pmem_resp = 0;
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have instruction-side ports: mem_read1  in  1  fetch request; mem_addr1  in  16  fetch address; mem_rdata1  out  16  fetch data; mem_resp1  out  1  fetch done.
REQ-003 SHALL have data-side ports: mem_read2  in  1  load request; mem_write2  in  1  store request; mem_addr2  in  16  address; mem_wdata2  in  16  store data; mem_byte_enable2  in  2  store byte lanes; mem_rdata2  out  16  load data; mem_resp2  out  1  data done.
REQ-004 SHALL have physical-side ports: pmem_read  out  1; pmem_write  out  1; pmem_address  out  16; pmem_wdata  out  16; pmem_byte_enable  out  2; pmem_rdata  in  16; pmem_resp  in  1  transaction complete.

Function
REQ-005 SHALL implement a three-state FSM: IDLE, SERVE_I, SERVE_D.
REQ-006 In IDLE, with mem_read2 or mem_write2 asserted, SHALL move to SERVE_D next edge; else with mem_read1 asserted SHALL move to SERVE_I; else SHALL stay in IDLE.
REQ-007 On leaving IDLE SHALL latch the granted port's address, wdata, byte enable and read/write kind into internal registers; the pmem_* address, data and enable outputs SHALL be driven only from these registers.
REQ-008 In SERVE_I SHALL assert pmem_read; in SERVE_D SHALL assert the latched one of pmem_read/pmem_write; in IDLE both SHALL be 0.
REQ-009 The strobes SHALL stay asserted with stable address/data until the cycle pmem_resp=1.
REQ-010 mem_resp1 SHALL equal pmem_resp AND state==SERVE_I; mem_resp2 SHALL equal pmem_resp AND state==SERVE_D; both are combinational, single-cycle.
REQ-011 mem_rdata1 and mem_rdata2 SHALL both pass pmem_rdata through combinationally; data is valid only in the requester's resp cycle.
REQ-012 On pmem_resp=1 in a SERVE state SHALL return to IDLE next edge; minimum turnaround is one IDLE cycle between transactions.
REQ-013 pmem_resp while in IDLE SHALL be ignored and produce no resp.
REQ-014 A request deasserted mid-service SHALL NOT abort the transaction; the arbiter SHALL complete it and still pulse the resp.
REQ-015 mem_read2 and mem_write2 both asserted SHALL be treated as a write.
REQ-016 Changes to the mem_addr/wdata inputs during SERVE SHALL NOT affect pmem_* outputs.
REQ-017 A request held high after its resp SHALL be treated as a new request and re-arbitrated in IDLE.

Reset
REQ-018 reset=1 SHALL immediately, without a clock edge, force state IDLE, pmem_read=0, pmem_write=0, and clear the latched address, wdata and byte-enable registers to 0.
REQ-019 Reset mid-transaction SHALL abandon it with no resp pulse; a pmem_resp arriving after reset release SHALL be ignored per REQ-013.
REQ-020 After reset release, the first arbitration SHALL occur on the first rising clk edge.

Configuration
REQ-021 With macro MEM_ARBITER_RR_EN defined, SHALL keep a 1-bit last-grant register (reset 0 = last was data port); when both ports request in IDLE, the port not granted last SHALL win.
REQ-022 With MEM_ARBITER_RR_EN undefined, the data port SHALL have fixed priority per REQ-006 and no last-grant register SHALL exist.

Verification
REQ-023 Fetch only: mem_read1=1, addr1=0x3000, pmem_resp after 3 cycles with rdata=0x1234 -> pmem_address=0x3000 held, mem_resp1 pulses once with mem_rdata1=0x1234, mem_resp2 stays 0.
REQ-024 Simultaneous requests: read1 addr 0x3000 and write2 addr 0x4000, wdata 0xBEEF, be=2'b01 -> data served first (pmem_write, 0x4000, 0xBEEF, 01), then fetch; with MEM_ARBITER_RR_EN and both held, grants alternate D,I,D,I.
REQ-025 Address change mid-service: addr2 changes 0x4000->0x5000 during SERVE_D -> pmem_address stays 0x4000 until pmem_resp.
REQ-026 Reset mid-transaction: reset pulse during SERVE_I -> pmem_read drops in the same cycle, no mem_resp1; a later stray pmem_resp produces no resp.
REQ-027 Stray resp: pmem_resp=1 in IDLE with no requests -> mem_resp1=mem_resp2=0, state stays IDLE.
REQ-028 Read+write together: mem_read2=mem_write2=1 -> pmem_write=1, pmem_read=0 for the full transaction.
